inst_buffer: RTL

//  Circular FIFO of FETCH_PACKETs between fetch and decode/dispatch.
//  - Absorbs up to IN_WIDTH fetched instructions per cycle.
//  - Presents the oldest OUT_WIDTH entries, in program order, to the decoder array.
//  - Retires entries as dispatch consumes them; flushes completely on branch mispredict.

---
 rtl/inst_buffer.sv | 119 +++++++++++
 1 files changed

// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO of fetch packets between fetch and decode.
// Optional IBUFF_STATS_EN adds stall_cycles / flushed_insts counters.
package inst_buffer_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_packet_t;
endpackage

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  fetch_packet_t [IN_WIDTH-1:0]      fetch_packets,
    input  logic [$clog2(IN_WIDTH+1)-1:0]     num_fetched,
    input  logic [$clog2(OUT_WIDTH+1)-1:0]    num_dispatched,
    input  logic                              flush,
    output fetch_packet_t [OUT_WIDTH-1:0]     ibuff_packets,
    output logic [$clog2(OUT_WIDTH+1)-1:0]    num_valid,
    output logic [$clog2(DEPTH+1)-1:0]        ibuff_open
`ifdef IBUFF_STATS_EN
    ,
    output logic [31:0]                       stall_cycles,
    output logic [31:0]                       flushed_insts
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int FW = $clog2(IN_WIDTH+1);
    localparam int DW = $clog2(OUT_WIDTH+1);

    fetch_packet_t mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [FW-1:0] fetch_eff;
    logic [DW-1:0] disp_eff;

    // Occupancy views and clamped handshakes (never overwrite or underflow)
    always_comb begin
        ibuff_open = CW'(DEPTH) - count;
        num_valid  = (count >= CW'(OUT_WIDTH)) ? DW'(OUT_WIDTH) : DW'(count);
        fetch_eff  = (CW'(num_fetched) > ibuff_open) ? FW'(ibuff_open)
                                                     : num_fetched;
        disp_eff   = (num_dispatched > num_valid) ? num_valid
                                                  : num_dispatched;
    end

    // Present oldest entries in order; unused lanes drive zero
    always_comb begin
        for (int i = 0; i < OUT_WIDTH; i++) begin
            ibuff_packets[i] = '0;
            if (DW'(i) < num_valid)
                ibuff_packets[i] = mem[head + PW'(i)];
        end
    end

    // Pointer and occupancy update; flush squashes all in-flight entries
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(disp_eff);
            tail  <= tail + PW'(fetch_eff);
            count <= count + CW'(fetch_eff) - CW'(disp_eff);
        end
    end

    // Entry storage; only slots free at the start of the cycle are written
    always_ff @(posedge clock) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (reset && !flush && (FW'(i) < fetch_eff))
                mem[tail + PW'(i)] <= fetch_packets[i];
        end
    end

`ifdef INST_BUFFER_CHECKS
    // Handshake protocol checks on the requester side
    always_ff @(posedge clock) begin
        if (reset && !flush) begin
            assert (CW'(num_fetched) <= ibuff_open)
                else $error("inst_buffer: enqueue beyond free space");
            assert (num_dispatched <= num_valid)
                else $error("inst_buffer: dispatch beyond valid entries");
        end
    end
`endif

`ifdef IBUFF_STATS_EN
    logic [32:0] flush_sum;
    assign flush_sum = {1'b0, flushed_insts} + 33'(count);

    // Saturating stall and flush counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles  <= '0;
            flushed_insts <= '0;
        end else begin
            if ((ibuff_open < CW'(IN_WIDTH)) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (flush)
                flushed_insts <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end
`endif

endmodule
